ex_div: RTL and testbench



---
 rtl/ex_div_pkg.sv | 20 ++
 rtl/ex_div_step.sv | 20 ++
 rtl/ex_div.sv | 144 ++++++++++++++
 tb/tb_ex_div.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_div_pkg.sv
// Shared encodings and constants for the execute-stage divider.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam int          DivIterations = 32;
    localparam logic [31:0] ZeroWord      = 32'h0;
    localparam logic [63:0] DoubleZero    = 64'h0;

endpackage

// File: rtl/ex_div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_o     = ~diff[W];
    assign rem_o   = q_o ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Build option DIV_EARLY_OUT_EN: zero dividend finishes on the short path.
import ex_div_pkg::*;

module ex_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                sign_quo_q, sign_quo_d;
    logic                sign_rem_q, sign_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W-1:0] abs1, abs2;
    logic [DATA_W-1:0] step_rem;
    logic              step_q;
    logic [DATA_W-1:0] quo_fix, rem_fix;
    logic              zero_path;

    assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign zero_path = (opdata2_i == '0) || (opdata1_i == '0);
`else
    assign zero_path = (opdata2_i == '0);
`endif

    // quo_q doubles as the dividend shift register; its MSB feeds each step
    div_step #(.W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[DATA_W-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign quo_fix = sign_quo_q ? -quo_q : quo_q;
    assign rem_fix = sign_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        unique case (state_q)
            DivFree: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    rem_d      = '0;
                    quo_d      = abs1;
                    divisor_d  = abs2;
                    cnt_d      = '0;
                    sign_quo_d = signed_div_i &
                                 (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    sign_rem_d = signed_div_i & opdata1_i[DATA_W-1];
                    state_d    = zero_path ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                result_d = '0;
                if (annul_i) begin
                    ready_d = DivResultNotReady;
                    state_d = DivFree;
                end else begin
                    ready_d = DivResultReady;
                    state_d = DivEnd;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[DATA_W-2:0], step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DivEnd: begin
                if (annul_i || start_i == DivStop) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: vector table, random model check, corners.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int tests;
    int errors;

`ifdef DIV_EARLY_OUT_EN
    localparam int EoLat = 2;
`else
    localparam int EoLat = 34;
`endif

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the one signed overflow case
    function automatic void model(input bit sgn, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r,
                                  output int lat);
        if (b == 0) begin
            q = 0; r = 0; lat = 2;
        end else begin
            lat = (a == 0) ? EoLat : 34;
            if (!sgn) begin
                q = a / b; r = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a; r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_div(input string name, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] elo, input logic [31:0] ehi,
                           input int elat, input bit scramble);
        int n;
        logic [63:0] held;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = $urandom_range(0, 1);
            end
        end while (!ready_o && n < 100);
        check({name, " lat"}, 64'(n), 64'(elat));
        check({name, " res"}, result_o, {ehi, elo});
        held = result_o;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check({name, " hold"}, {63'(0), ready_o} ^ {held ^ result_o}, 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, " clr"}, {result_o[62:0], ready_o}, 64'd0);
        check({name, " clrhi"}, 64'(result_o[63]), 64'd0);
        idle(1);
    endtask

    initial begin
        logic [31:0] a, b, q, r;
        logic [31:0] m;
        int lat;
        bit sgn;
        bit seen;

        tests = 0;
        errors = 0;
        rst = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = 0;
        opdata2_i = 0;
        start_i = 1'b0;
        annul_i = 1'b0;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
        tbl[2] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          34};
        tbl[3] = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          2};
        tbl[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          34};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          34};
        tbl[6] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          34};
        tbl[7] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          EoLat};
        tbl[8] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'd0,          32'd0,          2};
        tbl[9] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          34};

        idle(2);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 10; i++)
            run_div($sformatf("tbl%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
                    tbl[i].lo, tbl[i].hi, tbl[i].lat, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sgn = $urandom_range(0, 1);
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) b = 0;
            if ($urandom_range(0, 9) == 0) a = 0;
            if ($urandom_range(0, 3) == 0) b = -b;
            model(sgn, a, b, q, r, lat);
            run_div($sformatf("rnd%0d", i), sgn, a, b, q, r, lat, 1'b1);
        end

        // Flush at iteration 10: must go back to idle with no result
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        idle(11);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 1'b0;
        m = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
            m = m | result_o[31:0] | result_o[63:32];
        end
        check("annul ready", 64'(seen), 64'd0);
        check("annul result", 64'(m), 64'd0);
        run_div("post annul", 1'b0, 32'hFFFF_FFFF, 32'h10,
                32'h0FFF_FFFF, 32'hF, 34, 1'b0);

        // Reset at iteration 20, then a clean divide
        @(negedge clk);
        signed_div_i = 1'b1;
        opdata1_i = 32'hFFFF_0000;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        idle(21);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst mid ready", 64'(ready_o), 64'd0);
        check("rst mid result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        idle(1);
        run_div("post rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
